// File: rtl/tilexy_wb_inject.sv
// Writeback injector: buffers L2 cache-line writebacks and feeds them one per cycle
// into the mesh write FIFO, with a stall watchdog. Optional tail merge under `WB_MERGE_EN.
module tilexy_wb_inject #(
    parameter int DEPTH       = 4,
    parameter int STALL_LIMIT = 200
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wb_valid,
    output logic         wb_ready,
    input  logic [527:0] wb_data,
    input  logic [36:0]  wb_addr,
    input  logic [11:0]  wb_size,
    output logic         in_en,
    output logic [527:0] in_datum,
    output logic [36:0]  in_addr,
    output logic [11:0]  insize,
    input  logic         wrt_stall,
    output logic [4:0]   occupancy,
    output logic [7:0]   stall_cnt,
    output logic         hang
);

    localparam int DATA_W = 528;
    localparam int ADDR_W = 37;
    localparam int SIZE_W = 12;
    localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW     = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [7:0]    LIMIT_CNT = 8'(STALL_LIMIT);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [DATA_W-1:0] q_data [DEPTH];
    logic [ADDR_W-1:0] q_addr [DEPTH];
    logic [SIZE_W-1:0] q_size [DEPTH];
    logic [PW-1:0]     wptr, rptr;
    logic [CW-1:0]     count;

    logic              vld_p0;
    logic [DATA_W-1:0] data_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [SIZE_W-1:0] size_p0;

    logic xfer, load, q_empty, pop, hit, accept, bypass, push;

    assign q_empty = (count == '0);
    assign xfer    = vld_p0 & ~wrt_stall;
    assign load    = ~vld_p0 | xfer;
    assign pop     = load & ~q_empty;

`ifdef WB_MERGE_EN
    logic [PW-1:0] tail_ptr;
    assign tail_ptr = wptr - PW'(1);
    // A tail that is also the head being popped has left the queue; don't merge into it.
    assign hit = wb_valid & ~q_empty
               & (wb_addr == q_addr[tail_ptr])
               & (wb_size[11:10] == q_size[tail_ptr][11:10])
               & ~(pop & (count == CW'(1)));
`else
    assign hit = 1'b0;
`endif

    assign wb_ready = (count < FULL_CNT) | hit;
    assign accept   = wb_valid & wb_ready;
    assign bypass   = accept & load & q_empty;
    assign push     = accept & ~bypass & ~hit;

    assign in_en     = xfer;
    assign in_datum  = data_p0;
    assign in_addr   = addr_p0;
    assign insize    = size_p0;
    assign occupancy = 5'(count) + 5'(vld_p0);

    // Queue storage
    always_ff @(posedge clk) begin
        if (push) begin
            q_data[wptr] <= wb_data;
            q_addr[wptr] <= wb_addr;
            q_size[wptr] <= wb_size;
        end
`ifdef WB_MERGE_EN
        if (hit) begin
            q_data[tail_ptr] <= wb_data;
            q_size[tail_ptr] <= {q_size[tail_ptr][11:10], q_size[tail_ptr][9:0] | wb_size[9:0]};
        end
`endif
    end

    // Queue control and output register (stage p0)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            vld_p0    <= 1'b0;
            data_p0   <= '0;
            addr_p0   <= '0;
            size_p0   <= '0;
            stall_cnt <= '0;
            hang      <= 1'b0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (load) begin
                if (!q_empty) begin
                    vld_p0  <= 1'b1;
                    data_p0 <= q_data[rptr];
                    addr_p0 <= q_addr[rptr];
                    size_p0 <= q_size[rptr];
                end else if (bypass) begin
                    vld_p0  <= 1'b1;
                    data_p0 <= wb_data;
                    addr_p0 <= wb_addr;
                    size_p0 <= wb_size;
                end else begin
                    vld_p0  <= 1'b0;
                end
            end

            if (xfer) begin
                stall_cnt <= '0;
            end else if (vld_p0) begin
                stall_cnt <= sat_inc(stall_cnt);
                if (sat_inc(stall_cnt) == LIMIT_CNT) hang <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tilexy_wb_inject.sv
// Scoreboard bench for tilexy_wb_inject: expected beats are queued when writebacks
// are accepted and compared when the DUT presents in_en. Honours `WB_MERGE_EN.
module tb_tilexy_wb_inject;

    logic         clk;
    logic         rst;
    logic         wb_valid;
    logic         wb_ready;
    logic [527:0] wb_data;
    logic [36:0]  wb_addr;
    logic [11:0]  wb_size;
    logic         in_en;
    logic [527:0] in_datum;
    logic [36:0]  in_addr;
    logic [11:0]  insize;
    logic         wrt_stall;
    logic [4:0]   occupancy;
    logic [7:0]   stall_cnt;
    logic         hang;

    typedef struct packed {
        logic [36:0]  a;
        logic [527:0] d;
        logic [11:0]  s;
    } beat_t;

    beat_t sb[$];
    int    checks;
    int    failures;
    int    beats;
    bit    auto_push;

    tilexy_wb_inject #(.DEPTH(4), .STALL_LIMIT(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_data   (wb_data),
        .wb_addr   (wb_addr),
        .wb_size   (wb_size),
        .in_en     (in_en),
        .in_datum  (in_datum),
        .in_addr   (in_addr),
        .insize    (insize),
        .wrt_stall (wrt_stall),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt),
        .hang      (hang)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [527:0] mk_data();
        logic [527:0] d;
        d = '0;
        for (int i = 0; i < 33; i++) d[i*16 +: 16] = 16'($urandom());
        return d;
    endfunction

    // Sample mid-cycle, then advance past the next rising edge.
    task automatic tick();
        beat_t got, exp;
        @(negedge clk);
        if (auto_push && wb_valid && wb_ready)
            sb.push_back('{a: wb_addr, d: wb_data, s: wb_size});
        if (in_en) begin
            beats++;
            checks++;
            got = '{a: in_addr, d: in_datum, s: insize};
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_beat addr=%h size=%h", in_addr, insize);
            end else begin
                exp = sb.pop_front();
                if (got !== exp) begin
                    failures++;
                    $display("FAIL beat_order got addr=%h size=%h d=%h want addr=%h size=%h d=%h",
                             got.a, got.s, got.d[63:0], exp.a, exp.s, exp.d[63:0]);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        wb_valid  = 1'b0;
        wrt_stall = 1'b0;
        rst       = 1'b0;
        sb.delete();
        auto_push = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0 || in_en !== 1'b0) begin
            failures++;
            $display("FAIL drain pending=%0d in_en=%b want pending=0 in_en=0", sb.size(), in_en);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wb_valid = 1'b0; wrt_stall = 1'b0;
        wb_data = '0; wb_addr = '0; wb_size = '0;
        auto_push = 1'b1;
        #1 rst = 1'b0;
        #2;
        checks++; if (in_en !== 1'b0) begin failures++; $display("FAIL rst_in_en got=%b want=0", in_en); end
        checks++; if (wb_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b want=1", wb_ready); end
        checks++; if (occupancy !== 5'd0) begin failures++; $display("FAIL rst_occ got=%0d want=0", occupancy); end
        checks++; if (stall_cnt !== 8'd0 || hang !== 1'b0) begin failures++; $display("FAIL rst_status cnt=%0d hang=%b want 0/0", stall_cnt, hang); end
        checks++; if (in_addr !== 37'd0 || insize !== 12'd0) begin failures++; $display("FAIL rst_outreg addr=%h size=%h want 0", in_addr, insize); end
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_single();
        logic [527:0] d;
        d = mk_data();
        wb_addr = 37'h0_1234_5600; wb_data = d; wb_size = 12'h403; wb_valid = 1'b1;
        checks++; if (wb_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%b want=1", wb_ready); end
        tick();
        wb_valid = 1'b0;
        checks++;
        if (in_en !== 1'b1 || in_addr !== 37'h0_1234_5600 || insize !== 12'h403 || in_datum !== d) begin
            failures++;
            $display("FAIL single_latency in_en=%b addr=%h size=%h want 1/012345600/403", in_en, in_addr, insize);
        end
        checks++; if (occupancy !== 5'd1) begin failures++; $display("FAIL single_occ got=%0d want=1", occupancy); end
        tick();
        checks++;
        if (in_en !== 1'b0 || occupancy !== 5'd0 || sb.size() != 0) begin
            failures++;
            $display("FAIL single_done in_en=%b occ=%0d pending=%0d want 0/0/0", in_en, occupancy, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            wb_valid = 1'b1; wb_addr = 37'h1000 + 37'(i) * 37'd64; wb_data = mk_data(); wb_size = 12'(i + 1);
            checks++; if (wb_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready i=%0d got=%b want=1", i, wb_ready); end
            tick();
            checks++; if (in_en !== 1'b1) begin failures++; $display("FAIL b2b_stream i=%0d in_en=%b want=1", i, in_en); end
        end
        wb_valid = 1'b0;
        tick();
        checks++;
        if (in_en !== 1'b0 || sb.size() != 0) begin
            failures++;
            $display("FAIL b2b_end in_en=%b pending=%0d want 0/0", in_en, sb.size());
        end
    endtask

    task automatic test_full();
        int acc;
        do_reset();
        wrt_stall = 1'b1;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            wb_valid = 1'b1; wb_addr = 37'h2000 + 37'(acc) * 37'd64; wb_data = mk_data(); wb_size = 12'(acc);
            if (wb_ready) acc++;
            tick();
        end
        wb_addr = 37'h2000 + 37'(acc) * 37'd64;
        #1;
        checks++; if (acc != 5) begin failures++; $display("FAIL full_accepted got=%0d want=5", acc); end
        checks++; if (wb_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b want=0", wb_ready); end
        checks++; if (occupancy !== 5'd5) begin failures++; $display("FAIL full_occ got=%0d want=5", occupancy); end
        checks++;
        if (in_en !== 1'b0 || in_addr !== 37'h2000 || insize !== 12'd0) begin
            failures++;
            $display("FAIL full_stable in_en=%b addr=%h size=%h want 0/2000/000", in_en, in_addr, insize);
        end
        wb_valid = 1'b0;
        wrt_stall = 1'b0;
        tick();
        checks++; if (wb_ready !== 1'b1 || occupancy !== 5'd4) begin failures++; $display("FAIL full_recover ready=%b occ=%0d want 1/4", wb_ready, occupancy); end
        drain();
    endtask

    task automatic test_watchdog();
        do_reset();
        wrt_stall = 1'b1;
        wb_valid = 1'b1; wb_addr = 37'h3000; wb_data = mk_data(); wb_size = 12'h155;
        tick();
        wb_valid = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            tick();
            if (j == 9) begin
                checks++;
                if (hang !== 1'b0 || stall_cnt !== 8'd9) begin failures++; $display("FAIL wd_before hang=%b cnt=%0d want 0/9", hang, stall_cnt); end
            end
            if (j == 10) begin
                checks++;
                if (hang !== 1'b1 || stall_cnt !== 8'd10) begin failures++; $display("FAIL wd_limit hang=%b cnt=%0d want 1/10", hang, stall_cnt); end
            end
        end
        checks++; if (stall_cnt !== 8'd12 || in_en !== 1'b0) begin failures++; $display("FAIL wd_count cnt=%0d in_en=%b want 12/0", stall_cnt, in_en); end
        wrt_stall = 1'b0;
        #1;
        checks++; if (in_en !== 1'b1) begin failures++; $display("FAIL wd_release in_en=%b want=1", in_en); end
        tick();
        checks++;
        if (stall_cnt !== 8'd0 || hang !== 1'b1 || occupancy !== 5'd0) begin
            failures++;
            $display("FAIL wd_sticky cnt=%0d hang=%b occ=%0d want 0/1/0", stall_cnt, hang, occupancy);
        end
    endtask

    task automatic test_reset_mid();
        int b0;
        do_reset();
        wrt_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wb_valid = 1'b1; wb_addr = 37'h4000 + 37'(i) * 37'd64; wb_data = mk_data(); wb_size = 12'(i);
            tick();
        end
        wb_valid = 1'b0;
        #1;
        checks++; if (occupancy !== 5'd4) begin failures++; $display("FAIL mid_occ_before got=%0d want=4", occupancy); end
        #1;
        rst = 1'b0;
        wrt_stall = 1'b0;
        #1;
        checks++;
        if (in_en !== 1'b0 || occupancy !== 5'd0 || wb_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset in_en=%b occ=%0d ready=%b want 0/0/1", in_en, occupancy, wb_ready);
        end
        sb.delete();
        b0 = beats;
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (6) tick();
        checks++; if (beats != b0) begin failures++; $display("FAIL mid_stale beats=%0d want=0", beats - b0); end
    endtask

    task automatic test_merge();
        logic [527:0] dy, d1, d2;
        int b0, want_beats;
        do_reset();
        auto_push = 1'b0;
        wrt_stall = 1'b1;
        dy = mk_data(); d1 = mk_data(); d2 = mk_data();
        wb_valid = 1'b1; wb_addr = 37'h5000; wb_data = dy; wb_size = 12'h000;
        tick();
        wb_addr = 37'h5340; wb_data = d1; wb_size = 12'h003;
        tick();
        wb_data = d2; wb_size = 12'h00C;
        checks++; if (wb_ready !== 1'b1) begin failures++; $display("FAIL merge_ready got=%b want=1", wb_ready); end
        tick();
        wb_valid = 1'b0;
        sb.push_back('{a: 37'h5000, d: dy, s: 12'h000});
`ifdef WB_MERGE_EN
        sb.push_back('{a: 37'h5340, d: d2, s: 12'h00F});
        want_beats = 2;
`else
        sb.push_back('{a: 37'h5340, d: d1, s: 12'h003});
        sb.push_back('{a: 37'h5340, d: d2, s: 12'h00C});
        want_beats = 3;
`endif
        #1;
        checks++; if (occupancy !== 5'(want_beats)) begin failures++; $display("FAIL merge_occ got=%0d want=%0d", occupancy, want_beats); end
        wrt_stall = 1'b0;
        b0 = beats;
        drain();
        checks++; if (beats - b0 != want_beats) begin failures++; $display("FAIL merge_beats got=%0d want=%0d", beats - b0, want_beats); end
        auto_push = 1'b1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        beats = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_watchdog();
        test_reset_mid();
        test_merge();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
